// File: rtl/rsc_viterbi_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rsc_viterbi_decoder
// Description : Hard-decision Viterbi decoder for the 4-state rate-1/2
//               recursive systematic code (feedback 7, outputs {5,7}).
//               Accepts one frame of FRAME_LEN code symbols, runs ACS per
//               symbol, traces back once through the whole frame, then
//               streams the decoded bits in original order together with
//               the winning path metric.
// Ports       : clk, reset (async, active-high)
//               in_valid/in_ready/in_sym     : code symbol stream
//                 in_sym[1] = systematic (poly 7), in_sym[0] = parity (poly 5)
//               out_valid/out_ready/out_bit  : decoded bit stream
//               out_last                     : final bit of the frame
//               out_metric                   : Hamming distance of the
//                                              decoded codeword
// Revision    : 1.0 - initial release
// ============================================================================
module rsc_viterbi_decoder #(
  parameter int FRAME_LEN = 10,
  parameter int METRIC_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_sym,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_bit,
  output logic                out_last,
  output logic [METRIC_W-1:0] out_metric
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(FRAME_LEN - 1);

  localparam logic [1:0] c_ACS   = 2'd0;
  localparam logic [1:0] c_TRACE = 2'd1;
  localparam logic [1:0] c_OUT   = 2'd2;

  localparam logic [METRIC_W-1:0] c_PM_MAX = {METRIC_W{1'b1}};
  // State 0 is the only legal start state; the others begin "unreachable".
  localparam logic [3:0][METRIC_W-1:0] c_PM_INIT =
    {c_PM_MAX, c_PM_MAX, c_PM_MAX, {METRIC_W{1'b0}}};

  logic [1:0]                    r_state;
  logic [1:0]                    w_state_nxt;
  logic                          r_armed;
  logic [CW-1:0]                 r_cnt;
  logic [3:0][METRIC_W-1:0]      r_pm;
  logic [3:0][METRIC_W-1:0]      w_pm_nxt;
  logic [3:0]                    w_dec;
  logic [FRAME_LEN-1:0][3:0]     r_surv;
  logic [FRAME_LEN-1:0]          r_dbuf;
  logic [1:0]                    r_cur;
  logic                          r_first;
  logic [1:0]                    w_best;
  logic [1:0]                    w_cur;
  logic                          w_tb_dec;
  logic                          w_tb_u;
  logic                          w_in_fire;
  logic                          w_out_fire;

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] pm,
                                                  input logic [1:0]          bm);
    logic [METRIC_W:0] s;
    s = {1'b0, pm} + {{(METRIC_W-1){1'b0}}, bm};
    return s[METRIC_W] ? c_PM_MAX : s[METRIC_W-1:0];
  endfunction

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // --------------------------------------------------------------------------
  // Add-compare-select. Next state n = {a, s1}, so its two predecessors are
  // {n[0], s2} with s2 = 0/1; the decision bit is that s2. The input bit on
  // the branch is u = n[1]^n[0]^s2 and the parity is a^s2 = n[1]^s2.
  // --------------------------------------------------------------------------
  generate
    for (genvar n = 0; n < 4; n++) begin : g_acs
      localparam logic [1:0] c_NS = 2'(n);
      localparam logic [1:0] c_P0 = {c_NS[0], 1'b0};
      localparam logic [1:0] c_P1 = {c_NS[0], 1'b1};
      localparam logic       c_U0 = c_NS[1] ^ c_NS[0];
      localparam logic [1:0] c_E0 = {c_U0, c_NS[1]};
      localparam logic [1:0] c_E1 = {~c_U0, ~c_NS[1]};

      logic [METRIC_W-1:0] w_c0;
      logic [METRIC_W-1:0] w_c1;

      assign w_c0 = sat_add(r_pm[c_P0], hamming(in_sym, c_E0));
      assign w_c1 = sat_add(r_pm[c_P1], hamming(in_sym, c_E1));
      // Strict compare: a tie keeps the lower-index predecessor.
      assign w_dec[n]    = (w_c1 < w_c0);
      assign w_pm_nxt[n] = w_dec[n] ? w_c1 : w_c0;
    end
  endgenerate

  // Minimum path metric, lowest index wins a tie.
  always_comb begin
    w_best = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (r_pm[i] < r_pm[w_best]) w_best = 2'(i);
    end
  end

  // Traceback: first row starts from the best end state, later rows follow r_cur.
  assign w_cur    = r_first ? w_best : r_cur;
  assign w_tb_dec = r_surv[r_cnt][w_cur];
  assign w_tb_u   = w_cur[1] ^ w_cur[0] ^ w_tb_dec;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_ACS;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ACS:   if (w_in_fire && (r_cnt == c_LAST))  w_state_nxt = c_TRACE;
      c_TRACE: if (r_cnt == '0)                     w_state_nxt = c_OUT;
      c_OUT:   if (w_out_fire && (r_cnt == c_LAST)) w_state_nxt = c_ACS;
      default:                                      w_state_nxt = c_ACS;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (r_state == c_ACS) && r_armed;
    out_valid = (r_state == c_OUT);
    out_last  = (r_state == c_OUT) && (r_cnt == c_LAST);
    out_bit   = (r_state == c_OUT) && r_dbuf[r_cnt];
  end

  // --------------------------------------------------------------------------
  // Datapath. r_cnt is the symbol index in ACS, the traceback row in TRACE
  // (counting down) and the output index in OUT (counting up).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed    <= 1'b0;
      r_cnt      <= '0;
      r_pm       <= c_PM_INIT;
      r_surv     <= '0;
      r_dbuf     <= '0;
      r_cur      <= 2'd0;
      r_first    <= 1'b0;
      out_metric <= '0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        c_ACS: begin
          if (w_in_fire) begin
            r_pm          <= w_pm_nxt;
            r_surv[r_cnt] <= w_dec;
            if (r_cnt == c_LAST) r_first <= 1'b1;
            else                 r_cnt   <= r_cnt + CW'(1);
          end
        end
        c_TRACE: begin
          r_first <= 1'b0;
          if (r_first) out_metric <= r_pm[w_best];
          r_dbuf[r_cnt] <= w_tb_u;
          r_cur         <= {w_cur[0], w_tb_dec};
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        c_OUT: begin
          if (w_out_fire) begin
            if (r_cnt == c_LAST) begin
              r_cnt <= '0;
              r_pm  <= c_PM_INIT;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire
